prod_stock_counter: RTL

- Per-product inventory tracker for the vending machine. Sits directly upstream of the product-count LED stage.
- Holds a 4-bit stock count per product and arbitrates buy and restock requests through a small FSM.
- Drives prod_count_current, the stock of the currently selected product. The LED colour stage consumes it unchanged.

---
 rtl/prod_pkg.sv | 20 ++
 rtl/prod_stock_regfile.sv | 49 ++++
 rtl/prod_stock_counter.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/prod_pkg.sv
// Shared constants and FSM state type for the product stock counter and the LED stage.
package prod_pkg;

    localparam int COUNT_W        = 4;
    localparam int MAX_COUNT_DEF  = 9;
    localparam int INIT_COUNT_DEF = 5;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CHECK    = 2'd1,
        ST_DISPENSE = 2'd2
    } state_t;

    // Add one, holding at the ceiling instead of wrapping.
    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v,
                                                   input logic [COUNT_W-1:0] ceil);
        return (v >= ceil) ? ceil : v + 1'b1;
    endfunction

endpackage

// File: rtl/prod_stock_regfile.sv
// Per-product 4-bit stock array: saturating increment, guarded decrement, fill-all and one read port.
module prod_stock_regfile
    import prod_pkg::*;
#(
    parameter int NUM_PROD   = 4,
    parameter int SEL_W      = 2,
    parameter int MAX_COUNT  = MAX_COUNT_DEF,
    parameter int INIT_COUNT = INIT_COUNT_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_inc_en,
    input  logic [SEL_W-1:0]   i_inc_idx,
    input  logic               i_dec_en,
    input  logic [SEL_W-1:0]   i_dec_idx,
    input  logic               i_fill_en,
    input  logic [SEL_W-1:0]   i_rd_idx,
    output logic [COUNT_W-1:0] o_rd_data
);

    localparam logic [COUNT_W-1:0] MAX_C  = COUNT_W'(MAX_COUNT);
    localparam logic [COUNT_W-1:0] INIT_C = COUNT_W'(INIT_COUNT);

    logic [COUNT_W-1:0] r_count [NUM_PROD];

    // Indices outside 0..NUM_PROD-1 match no entry, so they never modify state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_PROD; i++) r_count[i] <= INIT_C;
        end else if (i_fill_en) begin
            for (int i = 0; i < NUM_PROD; i++) r_count[i] <= MAX_C;
        end else begin
            for (int i = 0; i < NUM_PROD; i++) begin
                if (i_dec_en && (i_dec_idx == SEL_W'(i)) && (r_count[i] != '0))
                    r_count[i] <= r_count[i] - 1'b1;
                else if (i_inc_en && (i_inc_idx == SEL_W'(i)))
                    r_count[i] <= sat_inc(r_count[i], MAX_C);
            end
        end
    end

    // An invalid index reads as zero, which the top treats as sold out.
    always_comb begin
        o_rd_data = '0;
        for (int i = 0; i < NUM_PROD; i++)
            if (i_rd_idx == SEL_W'(i)) o_rd_data = r_count[i];
    end

endmodule

// File: rtl/prod_stock_counter.sv
// Vending-machine stock tracker: buy/restock FSM, dispense timer and registered display path.
// Optional macro PROD_RESTOCK_ALL_EN adds the restock_all input (fill every product to MAX_COUNT).
module prod_stock_counter
    import prod_pkg::*;
#(
    parameter int NUM_PROD    = 4,
    parameter int SEL_W       = 2,
    parameter int MAX_COUNT   = MAX_COUNT_DEF,
    parameter int INIT_COUNT  = INIT_COUNT_DEF,
    parameter int DISP_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [SEL_W-1:0]   prod_sel,
    input  logic               buy_req,
    input  logic               restock_req,
`ifdef PROD_RESTOCK_ALL_EN
    input  logic               restock_all,
`endif
    output logic [COUNT_W-1:0] prod_count_current,
    output logic               sold_out,
    output logic               busy,
    output logic               buy_ack,
    output logic               buy_nack,
    output logic               dispense,
    output logic [1:0]         dbg_state
);

    localparam int TMR_W = $clog2(DISP_CYCLES + 1);

    state_t             r_state;
    logic [SEL_W-1:0]   r_sel_q;
    logic [TMR_W-1:0]   r_timer;
    logic               r_busy;
    logic               r_ack;
    logic               r_nack;
    logic               r_dispense;
    logic [COUNT_W-1:0] r_disp_count;
    logic               r_sold_out;

    logic [COUNT_W-1:0] w_rd_count;
    logic               w_idle;
    logic               w_fill;
    logic               w_inc;
    logic               w_dec;

    assign w_idle = (r_state == ST_IDLE);
`ifdef PROD_RESTOCK_ALL_EN
    assign w_fill = w_idle && !buy_req && restock_all;
`else
    assign w_fill = 1'b0;
`endif
    assign w_inc  = w_idle && !buy_req && !w_fill && restock_req;
    assign w_dec  = (r_state == ST_CHECK) && r_ack;

    prod_stock_regfile #(
        .NUM_PROD   (NUM_PROD),
        .SEL_W      (SEL_W),
        .MAX_COUNT  (MAX_COUNT),
        .INIT_COUNT (INIT_COUNT)
    ) u_regfile (
        .clk       (clk),
        .rst       (rst),
        .i_inc_en  (w_inc),
        .i_inc_idx (prod_sel),
        .i_dec_en  (w_dec),
        .i_dec_idx (r_sel_q),
        .i_fill_en (w_fill),
        .i_rd_idx  (prod_sel),
        .o_rd_data (w_rd_count)
    );

    // The ack/nack decision is registered on entry to CHECK so the pulse is visible
    // during CHECK; nothing can change count[sel_q] in between, and the
    // decrement itself is applied at the end of CHECK.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_sel_q    <= '0;
            r_timer    <= '0;
            r_busy     <= 1'b0;
            r_ack      <= 1'b0;
            r_nack     <= 1'b0;
            r_dispense <= 1'b0;
        end else begin
            r_ack  <= 1'b0;
            r_nack <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (buy_req) begin
                        r_sel_q <= prod_sel;
                        r_state <= ST_CHECK;
                        r_busy  <= 1'b1;
                        if (w_rd_count != '0) r_ack  <= 1'b1;
                        else                  r_nack <= 1'b1;
                    end
                end
                ST_CHECK: begin
                    if (r_ack) begin
                        r_timer    <= TMR_W'(DISP_CYCLES);
                        r_dispense <= 1'b1;
                        r_state    <= ST_DISPENSE;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_DISPENSE: begin
                    if (r_timer == TMR_W'(1)) begin
                        r_timer    <= '0;
                        r_dispense <= 1'b0;
                        r_busy     <= 1'b0;
                        r_state    <= ST_IDLE;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                default: begin
                    r_timer    <= '0;
                    r_dispense <= 1'b0;
                    r_busy     <= 1'b0;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_disp_count <= '0;
            r_sold_out   <= 1'b1;
        end else begin
            r_disp_count <= w_rd_count;
            r_sold_out   <= (w_rd_count == '0);
        end
    end

    assign prod_count_current = r_disp_count;
    assign sold_out           = r_sold_out;
    assign busy               = r_busy;
    assign buy_ack            = r_ack;
    assign buy_nack           = r_nack;
    assign dispense           = r_dispense;
    assign dbg_state          = r_state;

endmodule
